// File: rtl/eth_sync_fifo_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : eth_sync_fifo_pkg
// Brief   : Shared constants and helpers for the eth sync FIFO controller.
// Revision: 1.0 - initial release
// ============================================================================
package eth_sync_fifo_pkg;

    localparam int OB_DEPTH    = 2;
    localparam int SRAM_RD_LAT = 1;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    localparam int OB_CNT_W = clog2(OB_DEPTH + 1);

endpackage
`default_nettype wire

// File: rtl/eth_fifo_out_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : eth_fifo_out_stage
// Brief   : 2-entry first-word-fall-through register buffer fed by SRAM reads.
// Revision: 1.0 - initial release
// ============================================================================
module eth_fifo_out_stage
    import eth_sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 88
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [OB_CNT_W-1:0]   cnt,
    output logic [DATA_WIDTH-1:0] head
);

    logic [DATA_WIDTH-1:0] r_mem_q [OB_DEPTH];
    logic [DATA_WIDTH-1:0] w_mem_d [OB_DEPTH];
    logic                  r_wr_idx_q;
    logic                  w_wr_idx_d;
    logic                  r_rd_idx_q;
    logic                  w_rd_idx_d;
    logic [OB_CNT_W-1:0]   r_cnt_q;
    logic [OB_CNT_W-1:0]   w_cnt_d;

    always_comb begin
        w_mem_d    = r_mem_q;
        w_wr_idx_d = r_wr_idx_q;
        w_rd_idx_d = r_rd_idx_q;
        w_cnt_d    = r_cnt_q;
        if (wr_en) begin
            w_mem_d[r_wr_idx_q] = wr_data;
            w_wr_idx_d          = ~r_wr_idx_q;
        end
        if (rd_en) begin
            w_rd_idx_d = ~r_rd_idx_q;
        end
        case ({wr_en, rd_en})
            2'b10:   w_cnt_d = r_cnt_q + OB_CNT_W'(1);
            2'b01:   w_cnt_d = r_cnt_q - OB_CNT_W'(1);
            default: w_cnt_d = r_cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < OB_DEPTH; i++) begin
                r_mem_q[i] <= '0;
            end
            r_wr_idx_q <= 1'b0;
            r_rd_idx_q <= 1'b0;
            r_cnt_q    <= '0;
        end else begin
            r_mem_q    <= w_mem_d;
            r_wr_idx_q <= w_wr_idx_d;
            r_rd_idx_q <= w_rd_idx_d;
            r_cnt_q    <= w_cnt_d;
        end
    end

    assign cnt  = r_cnt_q;
    assign head = r_mem_q[r_rd_idx_q];

endmodule
`default_nettype wire

// File: rtl/eth_sync_fifo_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : eth_sync_fifo_ctrl
// Brief   : Sync FIFO controller for an external 2-port SRAM with FWFT pop port.
//           Optional occupancy output enabled by ETH_SYNC_FIFO_COUNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module eth_sync_fifo_ctrl
    import eth_sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 88,
    parameter int ADDR_WIDTH = 10,
    parameter int FIFO_DEPTH = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_valid,
    output logic                  push_ready,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic                  pop_valid,
    input  logic                  pop_ready,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  sram_wr_cen,
    output logic [ADDR_WIDTH-1:0] sram_wr_a,
    output logic [DATA_WIDTH-1:0] sram_wr_d,
    output logic                  sram_rd_cen,
    output logic [ADDR_WIDTH-1:0] sram_rd_a,
    input  logic [DATA_WIDTH-1:0] sram_rd_q
`ifdef ETH_SYNC_FIFO_COUNT_EN
    ,
    output logic [ADDR_WIDTH+1:0] data_count
`endif
);

    localparam int                  c_cnt_w    = ADDR_WIDTH + 1;
    localparam int                  c_pend_w   = clog2(OB_DEPTH + SRAM_RD_LAT + 1);
    localparam logic [ADDR_WIDTH-1:0] c_ptr_last = ADDR_WIDTH'(FIFO_DEPTH - 1);
    localparam logic [c_cnt_w-1:0]  c_depth    = c_cnt_w'(FIFO_DEPTH);

    logic [ADDR_WIDTH-1:0] r_wr_ptr_q;
    logic [ADDR_WIDTH-1:0] w_wr_ptr_d;
    logic [ADDR_WIDTH-1:0] r_rd_ptr_q;
    logic [ADDR_WIDTH-1:0] w_rd_ptr_d;
    logic [c_cnt_w-1:0]    r_sram_cnt_q;
    logic [c_cnt_w-1:0]    w_sram_cnt_d;
    logic                  r_inflight_q;
    logic                  w_inflight_d;

    logic                  w_push_fire;
    logic                  w_pop_fire;
    logic                  w_rd_issue;
    logic [OB_CNT_W-1:0]   w_ob_cnt;
    logic [c_pend_w-1:0]   w_ob_pending;

    assign push_ready  = ~rst & (r_sram_cnt_q < c_depth);
    assign w_push_fire = push_valid & push_ready;
    assign pop_valid   = (w_ob_cnt != '0);
    assign w_pop_fire  = pop_valid & pop_ready;

    // Stage occupancy once the current pop and any landing read are settled.
    assign w_ob_pending = c_pend_w'(w_ob_cnt) + c_pend_w'(r_inflight_q) - c_pend_w'(w_pop_fire);
    assign w_rd_issue   = (r_sram_cnt_q != '0) & (w_ob_pending < c_pend_w'(OB_DEPTH));

    always_comb begin
        w_wr_ptr_d   = r_wr_ptr_q;
        w_rd_ptr_d   = r_rd_ptr_q;
        w_sram_cnt_d = r_sram_cnt_q;
        w_inflight_d = w_rd_issue;
        if (w_push_fire) begin
            w_wr_ptr_d = (r_wr_ptr_q == c_ptr_last) ? '0 : r_wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (w_rd_issue) begin
            w_rd_ptr_d = (r_rd_ptr_q == c_ptr_last) ? '0 : r_rd_ptr_q + ADDR_WIDTH'(1);
        end
        case ({w_push_fire, w_rd_issue})
            2'b10:   w_sram_cnt_d = r_sram_cnt_q + c_cnt_w'(1);
            2'b01:   w_sram_cnt_d = r_sram_cnt_q - c_cnt_w'(1);
            default: w_sram_cnt_d = r_sram_cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr_q   <= '0;
            r_rd_ptr_q   <= '0;
            r_sram_cnt_q <= '0;
            r_inflight_q <= 1'b0;
        end else begin
            r_wr_ptr_q   <= w_wr_ptr_d;
            r_rd_ptr_q   <= w_rd_ptr_d;
            r_sram_cnt_q <= w_sram_cnt_d;
            r_inflight_q <= w_inflight_d;
        end
    end

    // Address and data buses idle at zero whenever the port is not enabled.
    assign sram_wr_cen = ~w_push_fire;
    assign sram_wr_a   = w_push_fire ? r_wr_ptr_q : '0;
    assign sram_wr_d   = w_push_fire ? push_data  : '0;
    assign sram_rd_cen = ~w_rd_issue;
    assign sram_rd_a   = w_rd_issue  ? r_rd_ptr_q : '0;

    eth_fifo_out_stage #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_stage (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (r_inflight_q),
        .wr_data (sram_rd_q),
        .rd_en   (w_pop_fire),
        .cnt     (w_ob_cnt),
        .head    (pop_data)
    );

`ifdef ETH_SYNC_FIFO_COUNT_EN
    localparam int c_dc_w = ADDR_WIDTH + 2;

    logic [c_dc_w-1:0] r_data_count_q;
    logic [c_dc_w-1:0] w_data_count_d;

    assign w_data_count_d = c_dc_w'(w_sram_cnt_d) + c_dc_w'(w_inflight_d) + c_dc_w'(w_ob_pending);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_count_q <= '0;
        end else begin
            r_data_count_q <= w_data_count_d;
        end
    end

    assign data_count = r_data_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_eth_sync_fifo_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_eth_sync_fifo_ctrl
// Brief   : Self-checking bench for eth_sync_fifo_ctrl with a behavioural SRAM
//           and a queue-based reference model (ETH_SYNC_FIFO_COUNT_EN aware).
// Revision: 1.0 - initial release
// ============================================================================
module tb_eth_sync_fifo_ctrl;

    localparam int DW    = 88;
    localparam int AW    = 3;
    localparam int DEPTH = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          push_valid = 1'b0;
    logic          push_ready;
    logic [DW-1:0] push_data = '0;
    logic          pop_valid;
    logic          pop_ready = 1'b0;
    logic [DW-1:0] pop_data;
    logic          sram_wr_cen;
    logic [AW-1:0] sram_wr_a;
    logic [DW-1:0] sram_wr_d;
    logic          sram_rd_cen;
    logic [AW-1:0] sram_rd_a;
    logic [DW-1:0] sram_rd_q;
`ifdef ETH_SYNC_FIFO_COUNT_EN
    logic [AW+1:0] data_count;
`endif

    always #5 clk = ~clk;

    eth_sync_fifo_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .push_valid  (push_valid),
        .push_ready  (push_ready),
        .push_data   (push_data),
        .pop_valid   (pop_valid),
        .pop_ready   (pop_ready),
        .pop_data    (pop_data),
        .sram_wr_cen (sram_wr_cen),
        .sram_wr_a   (sram_wr_a),
        .sram_wr_d   (sram_wr_d),
        .sram_rd_cen (sram_rd_cen),
        .sram_rd_a   (sram_rd_a),
        .sram_rd_q   (sram_rd_q)
`ifdef ETH_SYNC_FIFO_COUNT_EN
        ,
        .data_count  (data_count)
`endif
    );

    // Behavioural 2-port SRAM with one cycle of read latency.
    logic [DW-1:0] sram_mem [DEPTH];
    always @(posedge clk) begin
        if (!sram_wr_cen) sram_mem[sram_wr_a] <= sram_wr_d;
        if (!sram_rd_cen) sram_rd_q <= sram_mem[sram_rd_a];
    end

    int            n_checks = 0;
    int            n_errors = 0;
    logic [DW-1:0] model_q [$];
    int            wr_k, rd_k, rd_pulses, cyc, n_pushed, n_popped;
    int            first_pop_cyc, last_pop_cyc;
    bit            last_push_fire;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock: sample at the falling edge, update the model, return 1ns after the rising edge.
    task automatic cycle();
        logic [DW-1:0] exp_d;
        @(negedge clk);
        check_eq("wr_cen", sram_wr_cen, !(push_valid && push_ready));
        if (!sram_rd_cen) begin
            check_eq("rd_addr", sram_rd_a, rd_k % DEPTH);
            rd_k++;
            rd_pulses++;
            check_eq("rd_behind_wr", rd_k <= wr_k, 1);
        end
        if (!sram_wr_cen) begin
            check_eq("wr_addr", sram_wr_a, wr_k % DEPTH);
            check_eq("wr_data", sram_wr_d, push_data);
            check_eq("capacity", model_q.size() < DEPTH + 2, 1);
            wr_k++;
        end
        if (pop_valid) check_eq("valid_has_data", model_q.size() != 0, 1);
        if (!push_ready) check_eq("ready_low_when_full", model_q.size() >= DEPTH, 1);
`ifdef ETH_SYNC_FIFO_COUNT_EN
        check_eq("data_count", data_count, model_q.size());
`endif
        if (pop_valid && pop_ready && model_q.size() != 0) begin
            exp_d = model_q.pop_front();
            check_eq("pop_data", pop_data, exp_d);
            n_popped++;
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
            last_pop_cyc = cyc;
        end
        last_push_fire = push_valid && push_ready;
        if (last_push_fire) begin
            model_q.push_back(push_data);
            n_pushed++;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        push_valid = 1'b1;
        push_data  = {DW{1'b1}};
        pop_ready  = 1'b1;
        #1;
        check_eq("rst_push_ready", push_ready, 0);
        check_eq("rst_pop_valid", pop_valid, 0);
        check_eq("rst_pop_data", pop_data, 0);
        check_eq("rst_wr_cen", sram_wr_cen, 1);
        check_eq("rst_rd_cen", sram_rd_cen, 1);
        check_eq("rst_wr_a", sram_wr_a, 0);
        check_eq("rst_rd_a", sram_rd_a, 0);
        check_eq("rst_wr_d", sram_wr_d, 0);
`ifdef ETH_SYNC_FIFO_COUNT_EN
        check_eq("rst_data_count", data_count, 0);
`endif
        model_q.delete();
        wr_k = 0; rd_k = 0; rd_pulses = 0; n_pushed = 0; n_popped = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        push_valid = 1'b0;
        pop_ready  = 1'b0;
        rst        = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int            nxt;
        logic [95:0]   rnd;
        cyc = 0;
        first_pop_cyc = -1;
        last_pop_cyc  = -1;
        do_reset();

        // Single word latency: valid appears two edges after the accepting edge.
        push_valid = 1'b1;
        push_data  = DW'(88'hA5);
        cycle();
        push_valid = 1'b0;
        check_eq("lat_edge_n", pop_valid, 0);
        cycle();
        check_eq("lat_edge_n1", pop_valid, 0);
        cycle();
        check_eq("lat_edge_n2_valid", pop_valid, 1);
        check_eq("lat_edge_n2_data", pop_data, 88'hA5);
        repeat (3) cycle();
        check_eq("rd_pulse_once", rd_pulses, 1);
        pop_ready = 1'b1;
        cycle();
        pop_ready = 1'b0;
        check_eq("empty_after_pop", pop_valid, 0);

        // Fill with no pops: SRAM depth plus two stage entries.
        nxt = 0;
        push_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            push_data = DW'(100 + nxt);
            cycle();
            if (last_push_fire) nxt++;
        end
        check_eq("full_accepted", nxt, DEPTH + 2);
        check_eq("full_ready_low", push_ready, 0);
`ifdef ETH_SYNC_FIFO_COUNT_EN
        check_eq("full_data_count", data_count, DEPTH + 2);
`endif
        // Push and pop together while full: ready returns one cycle later.
        push_data = DW'(100 + nxt);
        pop_ready = 1'b1;
        cycle();
        check_eq("full_push_ignored", model_q.size(), DEPTH + 1);
        check_eq("ready_next_cycle", push_ready, 1);
        push_valid = 1'b0;
        for (int i = 0; i < 40 && (model_q.size() != 0 || pop_valid); i++) cycle();
        pop_ready = 1'b0;
        check_eq("full_drained", model_q.size(), 0);
        check_eq("full_drained_valid", pop_valid, 0);

        // Streaming 0..99 with the consumer always ready.
        nxt = 0; n_popped = 0; first_pop_cyc = -1;
        pop_ready = 1'b1;
        for (int i = 0; i < 300 && n_popped < 100; i++) begin
            push_valid = (nxt < 100);
            push_data  = DW'(nxt);
            cycle();
            if (last_push_fire) nxt++;
        end
        push_valid = 1'b0;
        pop_ready  = 1'b0;
        check_eq("stream_count", n_popped, 100);
        check_eq("stream_no_bubbles", last_pop_cyc - first_pop_cyc, 99);

        // Random traffic against the scoreboard.
        n_pushed = 0; n_popped = 0;
        for (int i = 0; i < 10000; i++) begin
            rnd        = {$urandom, $urandom, $urandom};
            push_valid = $urandom_range(0, 1) == 1;
            push_data  = rnd[DW-1:0];
            pop_ready  = $urandom_range(0, 1) == 1;
            cycle();
        end
        push_valid = 1'b0;
        pop_ready  = 1'b1;
        for (int i = 0; i < 40 && (model_q.size() != 0 || pop_valid); i++) cycle();
        pop_ready = 1'b0;
        check_eq("rand_drained", model_q.size(), 0);
        check_eq("rand_no_loss", n_popped, n_pushed);

        // Reset with three entries held and a read in flight.
        push_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_data = DW'(200 + i);
            cycle();
        end
        push_valid = 1'b0;
        check_eq("held_before_rst", model_q.size(), 3);
        do_reset();
        pop_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_eq("post_rst_empty", pop_valid, 0);
        end
        push_valid = 1'b1;
        push_data  = DW'(88'h77);
        cycle();
        push_valid = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        check_eq("post_rst_popped", n_popped, 1);
        check_eq("post_rst_drained", model_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
